// File: rtl/iir_cascade_engine.sv
`default_nettype none
// ============================================================================
//  Module      : iir_cascade_engine
//  Description : Time-multiplexed cascade of NSEC biquad sections sharing a
//                single multiplier. One Q2.22 sample in, one filtered sample
//                out. Coefficients [b0 b1 b2 a1 a2] are fetched per section
//                from an external combinational ROM via coeff_addr.
//  Ports       : clk, rst         - clock, synchronous active-high reset
//                in_valid/in_ready/in_data    - sample input handshake
//                out_valid/out_ready/out_data - filtered output handshake
//                coeff_addr/coeff - ROM address (registered) and ROM data
//                busy             - high while computing (MAC/RND)
//                sat_flag         - sticky, any section output saturated
//  Revision    : 1.0 - initial release
// ============================================================================
module iir_cascade_engine #(
    parameter int DW    = 24,
    parameter int CW    = 24,
    parameter int FRAC  = 22,
    parameter int NSEC  = 4,
    parameter int ACC_W = 52
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] in_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_data,
    output logic [4:0]    coeff_addr,
    input  logic [CW-1:0] coeff,
    output logic          busy,
    output logic          sat_flag
);

    // Section index must be able to address node NSEC (the last output node).
    localparam int SEC_W  = $clog2(NSEC + 1);
    localparam int PROD_W = DW + CW;

    localparam logic signed [ACC_W-1:0] c_half    = {{(ACC_W-FRAC){1'b0}}, 1'b1, {(FRAC-1){1'b0}}};
    localparam logic signed [ACC_W-1:0] c_sat_max = {{(ACC_W-DW+1){1'b0}}, {(DW-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] c_sat_min = {{(ACC_W-DW+1){1'b1}}, {(DW-1){1'b0}}};
    localparam logic [4:0]              c_last_addr = 5'(5 * NSEC - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MAC  = 2'd1,
        S_RND  = 2'd2,
        S_OUT  = 2'd3
    } state_t;

    state_t                   state_q, state_d;
    logic [SEC_W-1:0]         sec_q, sec_d;
    logic [2:0]               tap_q, tap_d;
    logic [4:0]               addr_q, addr_d;
    logic signed [ACC_W-1:0]  acc_q, acc_d;
    logic signed [DW-1:0]     cur_q, cur_d;
    logic signed [DW-1:0]     d1_q [NSEC+1];
    logic signed [DW-1:0]     d1_d [NSEC+1];
    logic signed [DW-1:0]     d2_q [NSEC+1];
    logic signed [DW-1:0]     d2_d [NSEC+1];
    logic [DW-1:0]            out_data_q, out_data_d;
    logic                     out_valid_q, out_valid_d;
    logic                     sat_q, sat_d;

    logic [SEC_W-1:0]         w_sec_nxt;
    logic [DW-1:0]            w_operand;
    logic [PROD_W-1:0]        w_coeff_ext;
    logic [PROD_W-1:0]        w_opnd_ext;
    logic [PROD_W-1:0]        w_prod;
    logic signed [ACC_W-1:0]  w_prod_ext;
    logic signed [ACC_W-1:0]  w_rnd_sum;
    logic signed [ACC_W-1:0]  w_rnd_shift;
    logic                     w_sat_hi;
    logic                     w_sat_lo;
    logic [DW-1:0]            w_sat_val;

    assign w_sec_nxt = sec_q + 1'b1;

    // Operand select: taps 0-2 use the section input history (node sec),
    // taps 3-4 use the section output history (node sec+1).
    always_comb begin
        w_operand = d2_q[w_sec_nxt];
        case (tap_q)
            3'd0:    w_operand = cur_q;
            3'd1:    w_operand = d1_q[sec_q];
            3'd2:    w_operand = d2_q[sec_q];
            3'd3:    w_operand = d1_q[w_sec_nxt];
            default: w_operand = d2_q[w_sec_nxt];
        endcase
    end

    // Both operands sign-extended to the full product width, so the low
    // PROD_W bits of the unsigned multiply are the exact signed product.
    assign w_coeff_ext = {{DW{coeff[CW-1]}}, coeff};
    assign w_opnd_ext  = {{CW{w_operand[DW-1]}}, w_operand};
    assign w_prod      = w_coeff_ext * w_opnd_ext;
    assign w_prod_ext  = {{(ACC_W-PROD_W){w_prod[PROD_W-1]}}, w_prod};

    // Round half up, then arithmetic shift back to sample scale.
    assign w_rnd_sum   = acc_q + c_half;
    assign w_rnd_shift = w_rnd_sum >>> FRAC;
    assign w_sat_hi    = (w_rnd_shift > c_sat_max);
    assign w_sat_lo    = (w_rnd_shift < c_sat_min);
    assign w_sat_val   = w_sat_hi ? c_sat_max[DW-1:0] :
                         w_sat_lo ? c_sat_min[DW-1:0] : w_rnd_shift[DW-1:0];

    always_comb begin
        state_d     = state_q;
        sec_d       = sec_q;
        tap_d       = tap_q;
        addr_d      = addr_q;
        acc_d       = acc_q;
        cur_d       = cur_q;
        d1_d        = d1_q;
        d2_d        = d2_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        sat_d       = sat_q;

        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    cur_d   = in_data;
                    acc_d   = '0;
                    sec_d   = '0;
                    tap_d   = '0;
                    addr_d  = '0;
                    state_d = S_MAC;
                end
            end
            S_MAC: begin
                acc_d  = (tap_q < 3'd3) ? acc_q + w_prod_ext : acc_q - w_prod_ext;
                // Wrap after the final tap so the address parks at 0 for OUT.
                addr_d = (addr_q == c_last_addr) ? 5'd0 : addr_q + 5'd1;
                if (tap_q == 3'd4) begin
                    tap_d   = '0;
                    state_d = S_RND;
                end else begin
                    tap_d = tap_q + 3'd1;
                end
            end
            S_RND: begin
                d2_d[sec_q] = d1_q[sec_q];
                d1_d[sec_q] = cur_q;
                cur_d       = w_sat_val;
                acc_d       = '0;
                if (w_sat_hi || w_sat_lo) begin
                    sat_d = 1'b1;
                end
                if (sec_q == SEC_W'(NSEC - 1)) begin
                    d2_d[NSEC]  = d1_q[NSEC];
                    d1_d[NSEC]  = w_sat_val;
                    out_data_d  = w_sat_val;
                    out_valid_d = 1'b1;
                    state_d     = S_OUT;
                end else begin
                    sec_d   = w_sec_nxt;
                    state_d = S_MAC;
                end
            end
            default: begin
                addr_d = '0;
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = S_IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            sec_q       <= '0;
            tap_q       <= '0;
            addr_q      <= '0;
            acc_q       <= '0;
            cur_q       <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            sat_q       <= 1'b0;
            for (int k = 0; k <= NSEC; k++) begin
                d1_q[k] <= '0;
                d2_q[k] <= '0;
            end
        end else begin
            state_q     <= state_d;
            sec_q       <= sec_d;
            tap_q       <= tap_d;
            addr_q      <= addr_d;
            acc_q       <= acc_d;
            cur_q       <= cur_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            sat_q       <= sat_d;
            d1_q        <= d1_d;
            d2_q        <= d2_d;
        end
    end

    assign in_ready   = (state_q == S_IDLE);
    assign busy       = (state_q == S_MAC) || (state_q == S_RND);
    assign out_valid  = out_valid_q;
    assign out_data   = out_data_q;
    assign coeff_addr = addr_q;
    assign sat_flag   = sat_q;

endmodule
`default_nettype wire

// File: tb/tb_iir_cascade_engine.sv
`default_nettype none
// ============================================================================
//  Module      : tb_iir_cascade_engine
//  Description : Self-checking bench for iir_cascade_engine. Drives samples
//                through a combinational coefficient ROM and compares every
//                result with a direct-form-I reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_iir_cascade_engine;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [23:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [23:0] out_data;
    logic [4:0]  coeff_addr;
    logic [23:0] coeff;
    logic        busy;
    logic        sat_flag;

    int n_checks = 0;
    int n_pass   = 0;

    logic [23:0] rom_n [20];
    logic [23:0] rom_s [20];
    bit          rom_mode = 1'b0;

    // Reference model: per-section x and y history (direct form I).
    longint xh1 [4];
    longint xh2 [4];
    longint yh1 [4];
    longint yh2 [4];

    logic [23:0] imp_obs [64];

    always #5 clk = ~clk;

    assign coeff = (coeff_addr < 5'd20) ? (rom_mode ? rom_s[coeff_addr] : rom_n[coeff_addr]) : 24'h0;

    iir_cascade_engine dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .coeff_addr (coeff_addr),
        .coeff      (coeff),
        .busy       (busy),
        .sat_flag   (sat_flag)
    );

    function automatic longint coef(input int s, input int t);
        logic signed [23:0] v;
        v = rom_mode ? rom_s[5*s+t] : rom_n[5*s+t];
        return longint'(v);
    endfunction

    function automatic void model_reset();
        for (int s = 0; s < 4; s++) begin
            xh1[s] = 0; xh2[s] = 0; yh1[s] = 0; yh2[s] = 0;
        end
    endfunction

    function automatic logic [23:0] model_step(input logic [23:0] xin);
        longint x, acc, y;
        logic signed [23:0] xs;
        xs = xin;
        x  = longint'(xs);
        for (int s = 0; s < 4; s++) begin
            acc = coef(s,0)*x + coef(s,1)*xh1[s] + coef(s,2)*xh2[s]
                - coef(s,3)*yh1[s] - coef(s,4)*yh2[s];
            y = (acc + 64'sd2097152) >>> 22;
            if (y > 64'sd8388607)  y = 64'sd8388607;
            if (y < -64'sd8388608) y = -64'sd8388608;
            xh2[s] = xh1[s]; xh1[s] = x;
            yh2[s] = yh1[s]; yh1[s] = y;
            x = y;
        end
        return x[23:0];
    endfunction

    // Pushes one sample through, returns observed result and timing/handshake flags.
    task automatic run_sample(input logic [23:0] x, input int stall, input bit junk,
                              output logic [23:0] y, output int lat,
                              output bit seq_ok, output bit stall_ok);
        int c;
        int guard;
        seq_ok   = 1'b1;
        stall_ok = 1'b1;
        guard    = 0;
        out_ready = (stall == 0);
        while (in_ready !== 1'b1 && guard < 200) begin
            @(posedge clk); #1; guard++;
        end
        in_valid = 1'b1;
        in_data  = x;
        @(posedge clk); #1;
        in_valid = 1'b0;
        c = 0;
        while (out_valid !== 1'b1 && c < 60) begin
            if (c < 24) begin
                if (busy !== 1'b1) seq_ok = 1'b0;
                if ((c % 6) < 5 && coeff_addr !== 5'((c / 6) * 5 + (c % 6))) seq_ok = 1'b0;
            end
            if (junk) begin
                in_valid = 1'($urandom_range(0, 1));
                in_data  = 24'($urandom);
            end
            @(posedge clk); #1; c++;
        end
        lat = (guard >= 200) ? -1 : c;
        y   = out_data;
        if (busy !== 1'b0) seq_ok = 1'b0;
        for (int s = 0; s < stall; s++) begin
            if (out_valid !== 1'b1 || out_data !== y || in_ready !== 1'b0 || coeff_addr !== 5'd0)
                stall_ok = 1'b0;
            if (junk) begin
                in_valid = 1'b1;
                in_data  = 24'($urandom);
            end
            @(posedge clk); #1;
        end
        if (out_data !== y) stall_ok = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) stall_ok = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        model_reset();
        n_checks++; if (out_valid !== 1'b0)  $display("FAIL reset out_valid got %b exp 0", out_valid); else n_pass++;
        n_checks++; if (in_ready !== 1'b1)   $display("FAIL reset in_ready got %b exp 1", in_ready); else n_pass++;
        n_checks++; if (coeff_addr !== 5'd0) $display("FAIL reset coeff_addr got %0d exp 0", coeff_addr); else n_pass++;
        n_checks++; if (sat_flag !== 1'b0)   $display("FAIL reset sat_flag got %b exp 0", sat_flag); else n_pass++;
        n_checks++; if (busy !== 1'b0)       $display("FAIL reset busy got %b exp 0", busy); else n_pass++;
        n_checks++; if (out_data !== 24'h0)  $display("FAIL reset out_data got %h exp 0", out_data); else n_pass++;
    endtask

    task automatic test_impulse(input bit compare_prev);
        logic [23:0] y, exp;
        int lat;
        bit seq_ok, stall_ok;
        rom_mode = 1'b0;
        for (int i = 0; i < 64; i++) begin
            exp = model_step((i == 0) ? 24'h400000 : 24'h000000);
            run_sample((i == 0) ? 24'h400000 : 24'h000000, 0, 1'b0, y, lat, seq_ok, stall_ok);
            n_checks++; if (y !== exp) $display("FAIL impulse[%0d] out_data got %h exp %h", i, y, exp); else n_pass++;
            n_checks++; if (lat !== 24) $display("FAIL impulse[%0d] latency got %0d exp 24", i, lat); else n_pass++;
            n_checks++; if (!seq_ok || !stall_ok) $display("FAIL impulse[%0d] addr/busy/handshake got %b%b exp 11", i, seq_ok, stall_ok); else n_pass++;
            if (compare_prev) begin
                n_checks++; if (y !== imp_obs[i]) $display("FAIL impulse_rerun[%0d] got %h exp %h", i, y, imp_obs[i]); else n_pass++;
            end else begin
                imp_obs[i] = exp;
            end
        end
        n_checks++; if (sat_flag !== 1'b0) $display("FAIL impulse sat_flag got %b exp 0", sat_flag); else n_pass++;
    endtask

    task automatic test_step();
        logic [23:0] y, exp;
        int lat;
        bit seq_ok, stall_ok;
        rst = 1'b1; @(posedge clk); #1 rst = 1'b0;
        model_reset();
        for (int i = 0; i < 3000; i++) begin
            exp = model_step(24'h100000);
            run_sample(24'h100000, 0, 1'b0, y, lat, seq_ok, stall_ok);
            n_checks++; if (y !== exp) $display("FAIL step[%0d] out_data got %h exp %h", i, y, exp); else n_pass++;
        end
        n_checks++; if (sat_flag !== 1'b0) $display("FAIL step sat_flag got %b exp 0", sat_flag); else n_pass++;
    endtask

    task automatic test_backpressure();
        logic [23:0] y, exp, x;
        int lat;
        bit seq_ok, stall_ok;
        for (int i = 0; i < 5; i++) begin
            x   = 24'($urandom_range(0, 24'h3FFFFF)) - 24'h200000;
            exp = model_step(x);
            run_sample(x, 10, 1'b0, y, lat, seq_ok, stall_ok);
            n_checks++; if (y !== exp) $display("FAIL backpressure[%0d] out_data got %h exp %h", i, y, exp); else n_pass++;
            n_checks++; if (!stall_ok) $display("FAIL backpressure[%0d] stall stability got 0 exp 1", i); else n_pass++;
        end
    endtask

    task automatic test_random_traffic();
        logic [23:0] y, exp, x;
        int lat;
        bit seq_ok, stall_ok;
        for (int i = 0; i < 40; i++) begin
            x   = 24'($urandom_range(0, 24'h3FFFFF)) - 24'h200000;
            exp = model_step(x);
            run_sample(x, int'($urandom_range(0, 3)), 1'b1, y, lat, seq_ok, stall_ok);
            n_checks++; if (y !== exp) $display("FAIL random[%0d] out_data got %h exp %h", i, y, exp); else n_pass++;
            n_checks++; if (lat !== 24 || !seq_ok || !stall_ok)
                $display("FAIL random[%0d] timing lat %0d seq %b stall %b exp 24 1 1", i, lat, seq_ok, stall_ok); else n_pass++;
        end
    endtask

    task automatic test_saturation();
        logic [23:0] y, exp;
        int lat;
        bit seq_ok, stall_ok;
        rom_mode = 1'b1;
        exp = model_step(24'h7FFFFF);
        run_sample(24'h7FFFFF, 0, 1'b0, y, lat, seq_ok, stall_ok);
        n_checks++; if (y !== 24'h7FFFFF || y !== exp) $display("FAIL sat out_data got %h exp 7fffff", y); else n_pass++;
        n_checks++; if (sat_flag !== 1'b1) $display("FAIL sat sat_flag got %b exp 1", sat_flag); else n_pass++;
        exp = model_step(24'h000000);
        run_sample(24'h000000, 0, 1'b0, y, lat, seq_ok, stall_ok);
        n_checks++; if (y !== 24'h000000 || y !== exp) $display("FAIL sat_zero out_data got %h exp 000000", y); else n_pass++;
        n_checks++; if (sat_flag !== 1'b1) $display("FAIL sat sticky sat_flag got %b exp 1", sat_flag); else n_pass++;
        rom_mode = 1'b0;
    endtask

    task automatic test_reset_mid_mac();
        int guard = 0;
        out_ready = 1'b1;
        while (in_ready !== 1'b1 && guard < 200) begin @(posedge clk); #1; guard++; end
        in_valid = 1'b1; in_data = 24'h123456;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        n_checks++; if (busy !== 1'b1) $display("FAIL midreset pre busy got %b exp 1", busy); else n_pass++;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        model_reset();
        n_checks++; if (in_ready !== 1'b1)   $display("FAIL midreset in_ready got %b exp 1", in_ready); else n_pass++;
        n_checks++; if (out_valid !== 1'b0)  $display("FAIL midreset out_valid got %b exp 0", out_valid); else n_pass++;
        n_checks++; if (busy !== 1'b0)       $display("FAIL midreset busy got %b exp 0", busy); else n_pass++;
        n_checks++; if (coeff_addr !== 5'd0) $display("FAIL midreset coeff_addr got %0d exp 0", coeff_addr); else n_pass++;
        n_checks++; if (sat_flag !== 1'b0)   $display("FAIL midreset sat_flag got %b exp 0", sat_flag); else n_pass++;
        test_impulse(1'b1);
    endtask

    initial begin
        for (int s = 0; s < 4; s++) begin
            rom_n[5*s+0] = 24'(32'h080000 + s * 32'h4000);
            rom_n[5*s+1] = 24'(32'h100000 - s * 32'h4000);
            rom_n[5*s+2] = 24'(32'h080000 + s * 32'h2000);
            rom_n[5*s+3] = 24'(-(32'sh200000 + s * 32'sh20000));
            rom_n[5*s+4] = 24'(32'h100000 - s * 32'h8000);
            rom_s[5*s+0] = 24'h7FFFFF;
            for (int t = 1; t < 5; t++) rom_s[5*s+t] = 24'h0;
        end
        test_reset();
        test_impulse(1'b0);
        test_step();
        test_backpressure();
        test_random_traffic();
        test_saturation();
        test_reset_mid_mac();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog simulation time limit reached, passed %0d of %0d", n_pass, n_checks);
        $fatal(1);
    end

endmodule
`default_nettype wire
